// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Latency: accepted on edge N, writeback cycle runs from edge N+32 to N+33, for every funct3.
// Backpressure: start is ignored while busy=1; nothing is queued, so the issuer must hold or retry.
//
// Ports:
//   clk, reset           single clock, asynchronous active-low reset
//   start, funct3        request strobe (sampled only in IDLE) and RV32M op select
//   rv1, rv2, rd_in      operands and destination register, latched on acceptance
//   busy                 high from the accepting edge until the writeback cycle ends
//   we, rd, indata       register file write port, valid during the single writeback cycle
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rv1,
    input  logic [31:0] rv2,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        we,
    output logic [4:0]  rd,
    output logic [31:0] indata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [2:0]  op;
    logic [4:0]  rd_q;
    logic [31:0] opnd;     // multiplicand magnitude (multiply) or divisor magnitude (divide)
    logic        neg_res;  // negate the final magnitude result
    logic [63:0] acc;      // multiply: running product; divide: {remainder, quotient/dividend}

    // Operand conditioning for a new request.
    logic        sa_in;
    logic        sb_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic        neg_in;

    always_comb begin
        sa_in    = 1'b0;
        sb_in    = 1'b0;
        neg_in   = 1'b0;
        case (funct3)
            3'b001, 3'b100, 3'b110: begin
                sa_in = rv1[31];
                sb_in = rv2[31];
            end
            3'b010: sa_in = rv1[31];
            default: ;
        endcase
        a_mag_in = sa_in ? (32'd0 - rv1) : rv1;
        b_mag_in = sb_in ? (32'd0 - rv2) : rv2;
        case (funct3)
            // Divide by zero keeps the all-ones quotient unsigned so DIV returns 0xFFFFFFFF.
            3'b100:  neg_in = (sa_in ^ sb_in) & (rv2 != 32'd0);
            3'b110:  neg_in = sa_in;
            default: neg_in = sa_in ^ sb_in;
        endcase
    end

    // One iteration of each algorithm.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] acc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next  = {mul_sum, acc[31:1]};
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // The true remainder always fits in 32 bits, so modulo-2^32 subtraction is exact.
        div_rem   = div_ge ? (div_shift[31:0] - opnd) : div_shift[31:0];
        div_next  = {div_rem, acc[30:0], div_ge};
        acc_next  = op[2] ? div_next : mul_next;
    end

    // Final result, formed from the value the last iteration produces.
    logic [63:0] prod_fix;
    logic [31:0] div_mag;
    logic [31:0] div_fix;
    logic [31:0] result;

    always_comb begin
        prod_fix = neg_res ? (64'd0 - acc_next) : acc_next;
        div_mag  = op[1] ? acc_next[63:32] : acc_next[31:0];
        div_fix  = neg_res ? (32'd0 - div_mag) : div_mag;
        if (op[2]) begin
            result = div_fix;
        end else if (op[1:0] == 2'b00) begin
            result = prod_fix[31:0];
        end else begin
            result = prod_fix[63:32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            op      <= 3'd0;
            rd_q    <= 5'd0;
            opnd    <= 32'd0;
            neg_res <= 1'b0;
            acc     <= 64'd0;
            busy    <= 1'b0;
            we      <= 1'b0;
            rd      <= 5'd0;
            indata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    we <= 1'b0;
                    if (start) begin
                        op      <= funct3;
                        rd_q    <= rd_in;
                        opnd    <= funct3[2] ? b_mag_in : a_mag_in;
                        acc     <= {32'd0, funct3[2] ? a_mag_in : b_mag_in};
                        neg_res <= neg_in;
                        cnt     <= 6'd0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state  <= WB;
                        // x0 is not protected downstream, so never write it.
                        we     <= (rd_q != 5'd0);
                        rd     <= rd_q;
                        indata <= result;
                    end
                end
                WB: begin
                    // start is not sampled here, so the earliest restart is the next edge.
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    we    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed RV32M vectors, randomized ops against an arithmetic model,
// timing of busy/we, restart spacing, ignored starts and reset abort.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rv1 = 32'd0;
    logic [31:0] rv2 = 32'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        busy;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] indata;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .rv1    (rv1),
        .rv2    (rv2),
        .rd_in  (rd_in),
        .busy   (busy),
        .we     (we),
        .rd     (rd),
        .indata (indata)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] u;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        u  = {32'd0, a} * {32'd0, b};
        r  = 32'd0;
        case (f)
            3'd0: r = u[31:0];
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
            3'd3: r = u[63:32];
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Waits through one accepted operation, starting just before its accepting edge.
    // Returns when busy is first seen low (sampled on falling edges).
    task automatic wait_op(input bit keep_start, input int pulse_at, output int cycles,
                           output int wb_cnt, output int wb_at, output logic [4:0] wb_rd,
                           output logic [31:0] wb_dat);
        cycles = 0; wb_cnt = 0; wb_at = 0; wb_rd = 5'd0; wb_dat = 32'd0;
        @(posedge clk);
        #1;
        if (!keep_start) begin
            // Scramble inputs after acceptance: the result must not depend on them.
            start  = 1'b0;
            funct3 = 3'($urandom);
            rv1    = $urandom;
            rv2    = $urandom;
            rd_in  = 5'($urandom);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cycles++;
            if (we) begin
                wb_cnt++;
                wb_at  = cycles;
                wb_rd  = rd;
                wb_dat = indata;
            end
            if (pulse_at != 0 && cycles == pulse_at) begin
                start = 1'b1;
                rv1   = $urandom;
                rv2   = $urandom;
            end else if (pulse_at != 0 && cycles == pulse_at + 1) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] r, input int cycles,
                            input int wb_cnt, input int wb_at, input logic [4:0] wb_rd,
                            input logic [31:0] wb_dat);
        logic [31:0] exp;
        int          exp_cnt;
        exp     = model(f, a, b);
        exp_cnt = (r != 5'd0) ? 1 : 0;
        vectors++;
        if (cycles !== 33) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected 33", name, cycles);
        end
        vectors++;
        if (wb_cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL %s we_pulses: got %0d expected %0d", name, wb_cnt, exp_cnt);
        end
        if (exp_cnt == 1) begin
            vectors++;
            if (wb_at !== 33 || wb_rd !== r || wb_dat !== exp) begin
                miscompares++;
                $display("FAIL %s f3=%0d a=%h b=%h: wb_at=%0d rd=%0d data=%h expected wb_at=33 rd=%0d data=%h",
                         name, f, a, b, wb_at, wb_rd, wb_dat, r, exp);
            end
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] r);
        int          cyc, wcnt, wat;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        @(negedge clk);
        funct3 = f; rv1 = a; rv2 = b; rd_in = r; start = 1'b1;
        wait_op(1'b0, 0, cyc, wcnt, wat, wrd, wdat);
        check_op(name, f, a, b, r, cyc, wcnt, wat, wrd, wdat);
    endtask

    task automatic test_reset();
        int          cyc, wcnt, wat;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        reset = 1'b0;
        @(negedge clk);
        funct3 = 3'd0; rv1 = 32'd7; rv2 = 32'hFFFFFFFD; rd_in = 5'd5; start = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || we !== 1'b0 || rd !== 5'd0 || indata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b we=%b rd=%0d indata=%h expected all zero", busy, we, rd, indata);
        end
        // Release with start already high: the first rising edge must accept it.
        reset = 1'b1;
        wait_op(1'b0, 0, cyc, wcnt, wat, wrd, wdat);
        check_op("first_after_reset", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, cyc, wcnt, wat, wrd, wdat);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    task automatic test_directed();
        vec_t v[12];
        v[0]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        v[1]  = '{3'd1, 32'h80000000, 32'h80000000};
        v[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
        v[3]  = '{3'd4, 32'hFFFFFFF9, 32'd2};
        v[4]  = '{3'd6, 32'hFFFFFFF9, 32'd2};
        v[5]  = '{3'd5, 32'd100, 32'd7};
        v[6]  = '{3'd7, 32'd100, 32'd7};
        v[7]  = '{3'd4, 32'd5, 32'd0};
        v[8]  = '{3'd7, 32'd5, 32'd0};
        v[9]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF};
        v[10] = '{3'd6, 32'h80000000, 32'hFFFFFFFF};
        v[11] = '{3'd6, 32'hFFFFFFF9, 32'd0};
        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("directed%0d", i), v[i].f, v[i].a, v[i].b, 5'd1 + 5'(i));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [31:0] corner[6];
        corner[0] = 32'd0; corner[1] = 32'd1; corner[2] = 32'hFFFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'h7FFFFFFF; corner[5] = 32'd2;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
            run_check($sformatf("random%0d", i), 3'($urandom), a, b, 5'($urandom_range(1, 31)));
        end
    endtask

    task automatic test_rd_zero();
        run_check("rd_zero", 3'd0, 32'd3, 32'd4, 5'd0);
    endtask

    task automatic test_back_to_back();
        int          cyc, wcnt, wat;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        @(negedge clk);
        funct3 = 3'd1; rv1 = 32'h12345678; rv2 = 32'h9ABCDEF0; rd_in = 5'd9; start = 1'b1;
        wait_op(1'b1, 0, cyc, wcnt, wat, wrd, wdat);
        check_op("b2b_first", 3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd9, cyc, wcnt, wat, wrd, wdat);
        // start still high; the next edge (N+34) must accept the new request.
        funct3 = 3'd6; rv1 = 32'hDEADBEEF; rv2 = 32'd1234; rd_in = 5'd17;
        wait_op(1'b0, 0, cyc, wcnt, wat, wrd, wdat);
        check_op("b2b_second", 3'd6, 32'hDEADBEEF, 32'd1234, 5'd17, cyc, wcnt, wat, wrd, wdat);
    endtask

    task automatic test_ignore_start();
        int          cyc, wcnt, wat, extra;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        @(negedge clk);
        funct3 = 3'd5; rv1 = 32'hCAFEF00D; rv2 = 32'd77; rd_in = 5'd3; start = 1'b1;
        wait_op(1'b0, 10, cyc, wcnt, wat, wrd, wdat);
        check_op("ignore_start", 3'd5, 32'hCAFEF00D, 32'd77, 5'd3, cyc, wcnt, wat, wrd, wdat);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_start_queued: busy seen %0d cycles after op, expected 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int we_seen, busy_seen;
        we_seen = 0; busy_seen = 0;
        @(negedge clk);
        funct3 = 3'd0; rv1 = 32'd11; rv2 = 32'd13; rd_in = 5'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (we) we_seen++;
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || we !== 1'b0 || rd !== 5'd0 || indata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_abort_outputs: busy=%b we=%b rd=%0d indata=%h expected all zero", busy, we, rd, indata);
        end
        repeat (3) begin
            @(negedge clk);
            if (we) we_seen++;
            if (busy) busy_seen++;
        end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (we) we_seen++;
            if (busy) busy_seen++;
        end
        vectors++;
        if (we_seen !== 0 || busy_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_abort_quiet: we_seen=%0d busy_seen=%0d expected 0 and 0", we_seen, busy_seen);
        end
        run_check("after_abort", 3'd4, 32'hFFFFFF00, 32'd16, 5'd30);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rd_zero();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width SHALL be fixed at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  input  1  single clock, all state updated on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 Port: start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 Port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port: rv1  input  32  operand A, taken from the register file first read port.
REQ-008 Port: rv2  input  32  operand B, taken from the register file second read port.
REQ-009 Port: rd_in  input  5  destination register index of the request.
REQ-010 Port: busy  output  1  high from the accepting edge until the writeback cycle ends.
REQ-011 Port: we  output  1  register file write enable.
REQ-012 Port: rd  output  5  register file write address.
REQ-013 Port: indata  output  32  register file write data (result).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, WB.
REQ-015 In IDLE with start=1 at edge N, the block SHALL latch funct3, rv1, rv2 and rd_in, clear a 6-bit iteration counter, and enter RUN.
REQ-016 Operand changes after edge N SHALL NOT affect the result.
REQ-017 RUN SHALL execute exactly one iteration per cycle for 32 cycles.
- Multiply: shift-add over a 64-bit product of magnitudes.
- Divide: restoring, one quotient bit per cycle.
REQ-018 At edge N+32 the block SHALL enter WB. During the WB cycle: we=1, rd=latched rd_in, indata=result. At edge N+33 it SHALL return to IDLE.
REQ-019 Latency SHALL be fixed at 33 cycles (start edge to WB cycle) for every funct3, including the special cases below.
REQ-020 start SHALL be ignored while busy=1; no request is queued.
REQ-021 busy SHALL be 1 in RUN and WB; we SHALL be 0 outside WB.
REQ-022 Signedness SHALL follow funct3:
- MULH: both operands signed.
- MULHSU: rv1 signed, rv2 unsigned.
- MULHU: both unsigned.
- MUL: low 32 bits of the product, identical for any signedness.
- Signed multiply SHALL use magnitudes with the 64-bit product negated when the operand signs differ.
REQ-023 DIV/REM SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rv1.
REQ-025 Signed overflow (rv1=0x80000000, rv2=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-026 If the latched rd_in is 0, we SHALL remain 0 in WB, because register x0 is not write-protected downstream; busy timing SHALL be unchanged.
REQ-027 A start in the same edge as the WB-to-IDLE transition SHALL be ignored; the earliest accepted restart is edge N+34.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, busy=0, we=0, rd=0, indata=0, counter=0, all operand and accumulator registers 0.
REQ-029 Reset asserted during RUN or WB SHALL abort the operation with no write issued; we SHALL not glitch high.
REQ-030 The first start SHALL be honoured at the first rising edge with reset=1 after deassertion.

Verification
REQ-031 MUL, rv1=7, rv2=0xFFFFFFFD, rd_in=5 -> WB 33 cycles later: we=1, rd=5, indata=0xFFFFFFEB; busy high for 33 cycles.
REQ-032 Multiply-high cases:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-034 Special cases:
- DIV 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
- All with 33-cycle latency.
REQ-035 rd_in=0 with MUL 3x4 -> busy for 33 cycles, we never asserted.
REQ-036 Back-to-back requests:
- start held high -> second operation accepted at edge N+34.
- Pulse start during RUN -> ignored.
- Assert reset at cycle 10 of RUN -> outputs 0 immediately; no we pulse; next start accepted normally.
